// File: rtl/calc_req_issuer_if.sv
// Request/response bus of the calculator request issuer: one request port in,
// one result strobe out. The issuer uses the slave modport, its client the master.
interface calc_req_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_chan;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;

  logic        rsp_valid;
  logic [1:0]  rsp_chan;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_chan, req_cmd, req_op1, req_op2,
    input  req_ready, rsp_valid, rsp_chan, rsp_code, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_chan, req_cmd, req_op1, req_op2,
    output req_ready, rsp_valid, rsp_chan, rsp_code, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/calc_req_issuer.sv
// Four independent channel FSMs issue cmd/op1 then op2 to the calculator and report
// captured results lowest-channel-first. Define CALC_ISSUER_TIMEOUT_EN for the WAIT timeout.
module calc_req_issuer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  calc_req_issuer_if.slave bus,
  output logic [3:0]       req1_cmd_out,
  output logic [3:0]       req2_cmd_out,
  output logic [3:0]       req3_cmd_out,
  output logic [3:0]       req4_cmd_out,
  output logic [31:0]      req1_data_out,
  output logic [31:0]      req2_data_out,
  output logic [31:0]      req3_data_out,
  output logic [31:0]      req4_data_out,
  input  logic [1:0]       out_resp1,
  input  logic [1:0]       out_resp2,
  input  logic [1:0]       out_resp3,
  input  logic [1:0]       out_resp4,
  input  logic [31:0]      out_data1,
  input  logic [31:0]      out_data2,
  input  logic [31:0]      out_data3,
  input  logic [31:0]      out_data4
);

  localparam int N_CH = 4;

  typedef enum logic [2:0] {IDLE, OP1, OP2, WAIT, DONE} ch_state_e;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("calc_req_issuer: TIMEOUT must lie in 2..255");
  end

  ch_state_e       state     [N_CH];
  ch_state_e       state_nxt [N_CH];
  logic [3:0]      cmd_q     [N_CH];
  logic [31:0]     op1_q     [N_CH];
  logic [31:0]     op2_q     [N_CH];
  logic [1:0]      code_q    [N_CH];
  logic [31:0]     data_q    [N_CH];
  logic [1:0]      resp_in   [N_CH];
  logic [31:0]     rdata_in  [N_CH];
  logic [3:0]      cmd_out   [N_CH];
  logic [31:0]     data_out  [N_CH];
  logic [N_CH-1:0] load;
  logic [N_CH-1:0] capture;
  logic            sel_valid;
  logic [1:0]      sel;
`ifdef CALC_ISSUER_TIMEOUT_EN
  logic [7:0]      wait_cnt  [N_CH];
  logic [N_CH-1:0] expire;
  logic [N_CH-1:0] tmo_q;
`endif

  assign resp_in[0]  = out_resp1;
  assign resp_in[1]  = out_resp2;
  assign resp_in[2]  = out_resp3;
  assign resp_in[3]  = out_resp4;
  assign rdata_in[0] = out_data1;
  assign rdata_in[1] = out_data2;
  assign rdata_in[2] = out_data3;
  assign rdata_in[3] = out_data4;

  assign req1_cmd_out  = cmd_out[0];
  assign req2_cmd_out  = cmd_out[1];
  assign req3_cmd_out  = cmd_out[2];
  assign req4_cmd_out  = cmd_out[3];
  assign req1_data_out = data_out[0];
  assign req2_data_out = data_out[1];
  assign req3_data_out = data_out[2];
  assign req4_data_out = data_out[3];

  assign bus.req_ready = (state[bus.req_chan] == IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    sel_valid = 1'b0;
    sel       = 2'd0;
    // Scan downwards so the lowest-index DONE channel wins the report slot.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (state[i] == DONE) begin
        sel_valid = 1'b1;
        sel       = 2'(i);
      end
    end

    for (int i = 0; i < N_CH; i++) begin
      state_nxt[i] = state[i];
      load[i]      = 1'b0;
      capture[i]   = 1'b0;
`ifdef CALC_ISSUER_TIMEOUT_EN
      expire[i]    = 1'b0;
`endif
      cmd_out[i]   = 4'd0;
      data_out[i]  = 32'd0;
      case (state[i])
        IDLE: begin
          if (bus.req_valid && bus.req_chan == 2'(i)) begin
            load[i]      = 1'b1;
            state_nxt[i] = OP1;
          end
        end
        OP1: begin
          cmd_out[i]   = cmd_q[i];
          data_out[i]  = op1_q[i];
          state_nxt[i] = OP2;
        end
        OP2: begin
          data_out[i]  = op2_q[i];
          state_nxt[i] = WAIT;
        end
        WAIT: begin
          // A real response on the final counted cycle still beats the timeout.
          if (resp_in[i] != 2'b00) begin
            capture[i]   = 1'b1;
            state_nxt[i] = DONE;
          end
`ifdef CALC_ISSUER_TIMEOUT_EN
          else if (wait_cnt[i] == 8'(TIMEOUT)) begin
            expire[i]    = 1'b1;
            state_nxt[i] = DONE;
          end
`endif
        end
        DONE: begin
          if (sel_valid && sel == 2'(i)) state_nxt[i] = IDLE;
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  assign bus.rsp_valid   = sel_valid;
  assign bus.rsp_chan    = sel;
  assign bus.rsp_code    = sel_valid ? code_q[sel] : 2'd0;
  assign bus.rsp_data    = sel_valid ? data_q[sel] : 32'd0;
`ifdef CALC_ISSUER_TIMEOUT_EN
  assign bus.rsp_timeout = sel_valid ? tmo_q[sel] : 1'b0;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // NOTE: state uses <= so every channel updates from the same pre-edge values.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      // NOTE: the small operand/result arrays are reset too, so nothing stale survives reset.
      for (int i = 0; i < N_CH; i++) begin
        state[i]    <= IDLE;
        cmd_q[i]    <= 4'd0;
        op1_q[i]    <= 32'd0;
        op2_q[i]    <= 32'd0;
        code_q[i]   <= 2'd0;
        data_q[i]   <= 32'd0;
`ifdef CALC_ISSUER_TIMEOUT_EN
        wait_cnt[i] <= 8'd0;
        tmo_q[i]    <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= state_nxt[i];
        if (load[i]) begin
          cmd_q[i] <= bus.req_cmd;
          op1_q[i] <= bus.req_op1;
          op2_q[i] <= bus.req_op2;
        end
        if (capture[i]) begin
          code_q[i] <= resp_in[i];
          data_q[i] <= rdata_in[i];
`ifdef CALC_ISSUER_TIMEOUT_EN
          tmo_q[i]  <= 1'b0;
`endif
        end
`ifdef CALC_ISSUER_TIMEOUT_EN
        else if (expire[i]) begin
          code_q[i] <= 2'd0;
          data_q[i] <= 32'd0;
          tmo_q[i]  <= 1'b1;
        end
        // The first WAIT cycle counts as 1.
        if (state[i] == OP2) wait_cnt[i] <= 8'd1;
        else if (state[i] == WAIT) wait_cnt[i] <= wait_cnt[i] + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_calc_req_issuer.sv
// Self-checking bench for calc_req_issuer: vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_calc_req_issuer;
  localparam int unsigned TIMEOUT = 16;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  always #5 c_clk = ~c_clk;

  calc_req_issuer_if bus ();

  logic [1:0]  calc_resp [4];
  logic [31:0] calc_data [4];
  logic [3:0]  dut_cmd   [4];
  logic [31:0] dut_data  [4];

  calc_req_issuer #(.TIMEOUT(TIMEOUT)) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .bus           (bus),
    .req1_cmd_out  (dut_cmd[0]),
    .req2_cmd_out  (dut_cmd[1]),
    .req3_cmd_out  (dut_cmd[2]),
    .req4_cmd_out  (dut_cmd[3]),
    .req1_data_out (dut_data[0]),
    .req2_data_out (dut_data[1]),
    .req3_data_out (dut_data[2]),
    .req4_data_out (dut_data[3]),
    .out_resp1     (calc_resp[0]),
    .out_resp2     (calc_resp[1]),
    .out_resp3     (calc_resp[2]),
    .out_resp4     (calc_resp[3]),
    .out_data1     (calc_data[0]),
    .out_data2     (calc_data[1]),
    .out_data3     (calc_data[2]),
    .out_data4     (calc_data[3])
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  chan;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          delay;     // WAIT cycles with no response before the calculator answers
    logic [3:0]  exp_cmd;
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
    logic [1:0]  exp_code;
    logic [31:0] exp_data;
  } vec_t;

  // Reference model: one record per channel, phases derived from the acceptance edge.
  bit          m_busy [4];
  bit          m_done [4];
  int          m_acc  [4];
  int          m_resp_at [4];
  logic [3:0]  m_cmd  [4];
  logic [31:0] m_op1  [4];
  logic [31:0] m_op2  [4];
  logic [1:0]  m_code [4];
  logic [31:0] m_data [4];
  bit          m_tmo  [4];
  int          edge_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [1:0] ch, input logic [3:0] cmd,
                           input logic [31:0] op1, input logic [31:0] op2);
    bus.req_valid = v;
    bus.req_chan  = ch;
    bus.req_cmd   = cmd;
    bus.req_op1   = op1;
    bus.req_op2   = op2;
  endtask

  task automatic idle_inputs();
    drive_req(1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      calc_resp[i] = 2'b00;
      calc_data[i] = 32'd0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Only channel ch may carry a nonzero issue; all others must be quiet.
  task automatic check_issue(input string tag, input int ch, input logic [3:0] ecmd,
                             input logic [31:0] edata);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_ch%0d", tag, i), {dut_cmd[i], dut_data[i]},
            (i == ch) ? {ecmd, edata} : 36'h0);
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] ch,
                           input logic [1:0] code, input logic [31:0] data, input logic tmo);
    check(tag, {bus.rsp_valid, bus.rsp_chan, bus.rsp_code, bus.rsp_data, bus.rsp_timeout},
          {v, ch, code, data, tmo});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    drive_req(1'b1, v.chan, v.cmd, v.op1, v.op2);
    @(negedge c_clk); check({t, "_ready"}, bus.req_ready, 1'b1);
    tick();
    drive_req(1'b0, v.chan, 4'd0, 32'd0, 32'd0);
    @(negedge c_clk); check_issue({t, "_op1"}, v.chan, v.exp_cmd, v.exp_op1);
    tick();
    @(negedge c_clk); check_issue({t, "_op2"}, v.chan, 4'd0, v.exp_op2);
    tick();
    repeat (v.delay) begin
      @(negedge c_clk); check_rsp({t, "_wait"}, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      tick();
    end
    calc_resp[v.chan] = v.resp;
    calc_data[v.chan] = v.rdata;
    @(negedge c_clk); check_issue({t, "_waitq"}, v.chan, 4'd0, 32'd0);
    tick();
    calc_resp[v.chan] = 2'b00;
    calc_data[v.chan] = 32'h5A5A_0F0F;
    @(negedge c_clk); check_rsp({t, "_rsp"}, 1'b1, v.chan, v.exp_code, v.exp_data, 1'b0);
    tick();
    @(negedge c_clk);
    check_rsp({t, "_clear"}, 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    check({t, "_ready_again"}, bus.req_ready, 1'b1);
    tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
      m_tmo[i]  = 1'b0;
      m_acc[i]  = 0;
    end
    edge_n = 0;
  endtask

  task automatic drive_random();
    int nx;
    nx = edge_n + 1;
    drive_req(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), $urandom, $urandom);
    for (int ch = 0; ch < 4; ch++) begin
      if (m_busy[ch] && !m_done[ch] && nx >= m_acc[ch] + 3)
        calc_resp[ch] = (nx >= m_resp_at[ch]) ? 2'($urandom_range(1, 3)) : 2'b00;
      else
        calc_resp[ch] = 2'($urandom_range(0, 3));   // noise outside WAIT must be ignored
      calc_data[ch] = $urandom;
    end
  endtask

  task automatic compare_model();
    logic [3:0]  ec;
    logic [31:0] ed;
    int          ph;
    int          r;
    check("rnd_ready", bus.req_ready, !m_busy[bus.req_chan]);
    for (int ch = 0; ch < 4; ch++) begin
      ec = 4'd0;
      ed = 32'd0;
      if (m_busy[ch] && !m_done[ch]) begin
        ph = edge_n - m_acc[ch];
        if (ph == 0) begin ec = m_cmd[ch]; ed = m_op1[ch]; end
        else if (ph == 1) ed = m_op2[ch];
      end
      check($sformatf("rnd_issue_ch%0d", ch), {dut_cmd[ch], dut_data[ch]}, {ec, ed});
    end
    r = -1;
    for (int ch = 3; ch >= 0; ch--) if (m_done[ch]) r = ch;
    if (r < 0) check_rsp("rnd_rsp_none", 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    else check_rsp("rnd_rsp", 1'b1, 2'(r), m_code[r], m_data[r], m_tmo[r]);
  endtask

  // Advance the model across one rising edge using the inputs held during the last cycle.
  task automatic model_edge();
    int n;
    int rep;
    bit acc_ok;
    n   = edge_n + 1;
    rep = -1;
    for (int ch = 3; ch >= 0; ch--) if (m_done[ch]) rep = ch;
    acc_ok = bus.req_valid && !m_busy[bus.req_chan];
    for (int ch = 0; ch < 4; ch++) begin
      if (m_busy[ch] && !m_done[ch] && n >= m_acc[ch] + 3) begin
        if (calc_resp[ch] != 2'b00) begin
          m_done[ch] = 1'b1;
          m_code[ch] = calc_resp[ch];
          m_data[ch] = calc_data[ch];
          m_tmo[ch]  = 1'b0;
        end
`ifdef CALC_ISSUER_TIMEOUT_EN
        else if (n == m_acc[ch] + 2 + int'(TIMEOUT)) begin
          m_done[ch] = 1'b1;
          m_code[ch] = 2'b00;
          m_data[ch] = 32'd0;
          m_tmo[ch]  = 1'b1;
        end
`endif
      end
    end
    if (rep >= 0) begin
      m_busy[rep] = 1'b0;
      m_done[rep] = 1'b0;
    end
    if (acc_ok) begin
      m_busy[bus.req_chan]    = 1'b1;
      m_acc[bus.req_chan]     = n;
      m_cmd[bus.req_chan]     = bus.req_cmd;
      m_op1[bus.req_chan]     = bus.req_op1;
      m_op2[bus.req_chan]     = bus.req_op2;
      m_resp_at[bus.req_chan] = n + 3 + int'($urandom_range(0, 6));
`ifdef CALC_ISSUER_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) m_resp_at[bus.req_chan] = n + 1000;
`endif
    end
    edge_n = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{chan: 2'd0, cmd: 4'h1, op1: 32'h64, op2: 32'h27, resp: 2'b01, rdata: 32'h8B,
                delay: 0, exp_cmd: 4'h1, exp_op1: 32'h64, exp_op2: 32'h27,
                exp_code: 2'b01, exp_data: 32'h8B};
    vecs[1] = '{chan: 2'd1, cmd: 4'h0, op1: 32'hDEADBEEF, op2: 32'h12345678, resp: 2'b10,
                rdata: 32'hCAFEF00D, delay: 3, exp_cmd: 4'h0, exp_op1: 32'hDEADBEEF,
                exp_op2: 32'h12345678, exp_code: 2'b10, exp_data: 32'hCAFEF00D};
    vecs[2] = '{chan: 2'd2, cmd: 4'hF, op1: 32'hFFFFFFFF, op2: 32'h0, resp: 2'b11,
                rdata: 32'hFFFFFFFF, delay: 1, exp_cmd: 4'hF, exp_op1: 32'hFFFFFFFF,
                exp_op2: 32'h0, exp_code: 2'b11, exp_data: 32'hFFFFFFFF};
    vecs[3] = '{chan: 2'd3, cmd: 4'h7, op1: 32'h0, op2: 32'hFFFFFFFF, resp: 2'b01,
                rdata: 32'h0, delay: 5, exp_cmd: 4'h7, exp_op1: 32'h0,
                exp_op2: 32'hFFFFFFFF, exp_code: 2'b01, exp_data: 32'h0};
    vecs[4] = '{chan: 2'd3, cmd: 4'h8, op1: 32'h1, op2: 32'h2, resp: 2'b10,
                rdata: 32'h55AA55AA, delay: 0, exp_cmd: 4'h8, exp_op1: 32'h1,
                exp_op2: 32'h2, exp_code: 2'b10, exp_data: 32'h55AA55AA};
    vecs[5] = '{chan: 2'd1, cmd: 4'h2, op1: 32'h80000000, op2: 32'h7FFFFFFF, resp: 2'b11,
                rdata: 32'h3, delay: 10, exp_cmd: 4'h2, exp_op1: 32'h80000000,
                exp_op2: 32'h7FFFFFFF, exp_code: 2'b11, exp_data: 32'h3};
    // Answer arrives on the last counted WAIT cycle: the response must win over a timeout.
    vecs[6] = '{chan: 2'd0, cmd: 4'h3, op1: 32'hA, op2: 32'hB, resp: 2'b10,
                rdata: 32'h0BAD0BAD, delay: int'(TIMEOUT) - 1, exp_cmd: 4'h3, exp_op1: 32'hA,
                exp_op2: 32'hB, exp_code: 2'b10, exp_data: 32'h0BAD0BAD};

    // Reset state
    do_reset();
    @(negedge c_clk);
    check_issue("reset_issue", 0, 4'd0, 32'd0);
    check_rsp("reset_rsp", 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      bus.req_chan = 2'(c);
      #1 check($sformatf("reset_ready_ch%0d", c), bus.req_ready, 1'b1);
    end
    bus.req_chan = 2'd0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Busy channel stalls its requester; another channel is accepted meanwhile.
    do_reset();
    drive_req(1'b1, 2'd2, 4'h2, 32'hA0, 32'hB0);
    @(negedge c_clk); check("busy_first_ready", bus.req_ready, 1'b1);
    tick();
    drive_req(1'b1, 2'd2, 4'h3, 32'hC0, 32'hD0);
    repeat (3) begin
      @(negedge c_clk); check("busy_stall", bus.req_ready, 1'b0);
      tick();
    end
    drive_req(1'b1, 2'd3, 4'h4, 32'hE0, 32'hF0);
    @(negedge c_clk); check("busy_other_ready", bus.req_ready, 1'b1);
    tick();
    drive_req(1'b1, 2'd2, 4'h3, 32'hC0, 32'hD0);
    calc_resp[2] = 2'b10;
    calc_data[2] = 32'h7777_1234;
    @(negedge c_clk);
    check("busy_stall_wait", bus.req_ready, 1'b0);
    check("busy_ch3_op1", {dut_cmd[3], dut_data[3]}, {4'h4, 32'hE0});
    tick();
    calc_resp[2] = 2'b00;
    @(negedge c_clk);
    check_rsp("busy_ch2_rsp", 1'b1, 2'd2, 2'b10, 32'h7777_1234, 1'b0);
    check("busy_stall_done", bus.req_ready, 1'b0);
    tick();
    @(negedge c_clk); check("busy_released", bus.req_ready, 1'b1);
    tick();
    drive_req(1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    @(negedge c_clk); check("busy_second_op1", {dut_cmd[2], dut_data[2]}, {4'h3, 32'hC0});

    // Two channels answer on the same edge: reported lowest index first.
    do_reset();
    drive_req(1'b1, 2'd1, 4'h6, 32'h11, 32'h22);
    tick();
    drive_req(1'b1, 2'd3, 4'h9, 32'h33, 32'h44);
    tick();
    drive_req(1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    @(negedge c_clk);
    check("pair_ch1_op2", {dut_cmd[1], dut_data[1]}, {4'h0, 32'h22});
    check("pair_ch3_op1", {dut_cmd[3], dut_data[3]}, {4'h9, 32'h33});
    repeat (2) tick();
    calc_resp[1] = 2'b11; calc_data[1] = 32'hA1A1A1A1;
    calc_resp[3] = 2'b01; calc_data[3] = 32'hB3B3B3B3;
    tick();
    calc_resp[1] = 2'b00; calc_resp[3] = 2'b00;
    @(negedge c_clk); check_rsp("pair_first", 1'b1, 2'd1, 2'b11, 32'hA1A1A1A1, 1'b0);
    tick();
    @(negedge c_clk); check_rsp("pair_second", 1'b1, 2'd3, 2'b01, 32'hB3B3B3B3, 1'b0);
    tick();
    @(negedge c_clk); check_rsp("pair_empty", 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);

`ifdef CALC_ISSUER_TIMEOUT_EN
    // No calculator answer: timeout result after TIMEOUT WAIT cycles.
    do_reset();
    drive_req(1'b1, 2'd0, 4'h0, 32'h5, 32'h6);
    tick();
    drive_req(1'b0, 2'd1, 4'd0, 32'd0, 32'd0);
    @(negedge c_clk); check_issue("to_op1", 0, 4'h0, 32'h5);
    tick();
    @(negedge c_clk); check_issue("to_op2", 0, 4'h0, 32'h6);
    tick();
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      @(negedge c_clk); check_rsp($sformatf("to_wait%0d", i), 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
      tick();
    end
    @(negedge c_clk); check_rsp("to_rsp", 1'b1, 2'd0, 2'b00, 32'd0, 1'b1);
    tick();
    bus.req_chan = 2'd0;
    @(negedge c_clk);
    check_rsp("to_clear", 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    check("to_ready", bus.req_ready, 1'b1);
`endif

    // Reset while channel 0 waits: the request is discarded.
    do_reset();
    drive_req(1'b1, 2'd0, 4'h5, 32'hAAAA, 32'hBBBB);
    tick();
    drive_req(1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    calc_resp[0] = 2'b01;
    calc_data[0] = 32'h1234;
    tick();
    @(negedge c_clk);
    check_issue("rst_issue", 0, 4'd0, 32'd0);
    check_rsp("rst_rsp", 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    tick();
    reset = 1'b0;
    calc_resp[0] = 2'b00;
    @(negedge c_clk); check("rst_ready", bus.req_ready, 1'b1);
    repeat (3) begin
      tick();
      @(negedge c_clk); check_rsp("rst_no_rsp", 1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_random();
      @(negedge c_clk);
      compare_model();
      @(posedge c_clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_req_issuer.md
CALC_REQ_ISSUER -- requirements
Module: calc_req_issuer

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, WAIT-state cycle limit before a channel reports timeout (legal 2..255).
REQ-002 SHALL have ports: c_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: req_valid  input  1  request offered; req_ready  output  1  request accepted when both high at an edge.
REQ-005 SHALL have ports: req_chan  input  2  target channel (0..3 maps to calculator channels 1..4); req_cmd  input  4  command; req_op1, req_op2  input  32 each  operands.
REQ-006 SHALL have ports: reqN_cmd_out  output  4 and reqN_data_out  output  32, N=1..4, driving calculator reqN_cmd_in/reqN_data_in.
REQ-007 SHALL have ports: out_respN  input  2 and out_dataN  input  32, N=1..4, from calculator outputs.
REQ-008 SHALL have ports: rsp_valid  output  1  result strobe; rsp_chan  output  2; rsp_code  output  2  captured response; rsp_data  output  32; rsp_timeout  output  1.

Function
REQ-009 SHALL run one independent FSM per channel with states IDLE, OP1, OP2, WAIT, DONE.
REQ-010 SHALL drive req_ready high iff the channel selected by req_chan is IDLE (combinational from state and req_chan).
REQ-011 SHALL, on acceptance at edge k, latch cmd/op1/op2 and move that channel IDLE->OP1.
REQ-012 SHALL, in OP1 (cycle k+1), drive reqN_cmd_out=cmd and reqN_data_out=op1 from registers, then move to OP2.
REQ-013 SHALL, in OP2 (cycle k+2), drive reqN_cmd_out=0 and reqN_data_out=op2, then move to WAIT.
REQ-014 SHALL drive reqN_cmd_out=0 and reqN_data_out=0 in IDLE, WAIT and DONE.
REQ-015 SHALL, in WAIT, capture out_respN/out_dataN at the first edge where out_respN!=0 and move to DONE with timeout flag 0.
REQ-016 SHALL, in WAIT, count cycles from 1; when count reaches TIMEOUT with out_respN==0, capture code 0, data 0, timeout flag 1, and move to DONE.
REQ-017 SHALL, whenever any channel is DONE, select the lowest-index DONE channel and drive rsp_valid=1 with its rsp_chan/rsp_code/rsp_data/rsp_timeout that cycle; selected channel moves DONE->IDLE at the next edge; unselected DONE channels hold.
REQ-018 SHALL drive rsp_valid=0 and all rsp_* fields 0 when no channel is DONE.
REQ-019 SHALL forward cmd unmodified (invalid commands and cmd 0 are issued normally).
REQ-020 SHALL allow all four channels in flight simultaneously; acceptance to one channel in the same cycle another reports is legal.

Reset
REQ-021 SHALL, with reset high at an edge, force all channels IDLE, clear latched operands, counters and captures; reset overrides every other event.
REQ-022 SHALL present during/after reset: all reqN_* outputs 0, rsp_* 0, req_ready 1 (once reset low); in-flight or unreported results are discarded.

Configuration
REQ-023 SHALL implement timeout logic (REQ-016, rsp_timeout) only when CALC_ISSUER_TIMEOUT_EN is defined.
REQ-024 SHALL, without CALC_ISSUER_TIMEOUT_EN, wait in WAIT indefinitely until out_respN!=0 and tie rsp_timeout to 0; TIMEOUT parameter is then unused.

Verification
REQ-025 SHALL cover: chan 0, cmd 1, op1 0x64, op2 0x27, calculator returns resp 01 data 0x8B -> req1 out cmd1/0x64 at k+1, cmd0/0x27 at k+2; rsp_valid, chan 0, code 01, data 0x8B, timeout 0 one cycle after resp sampled.
REQ-026 SHALL cover: chan 2 busy, second request to chan 2 -> req_ready 0, stalled until chan 2 reports; concurrent request to chan 3 accepted immediately.
REQ-027 SHALL cover: chans 1 and 3 receive nonzero resp on the same edge -> rsp_chan 1 then rsp_chan 3 on consecutive cycles, both data intact.
REQ-028 SHALL cover (macro defined, TIMEOUT=16): cmd 0 on chan 0, no calculator response -> rsp_valid with code 00, data 0, timeout 1 after 16 WAIT cycles.
REQ-029 SHALL cover: reset asserted while chan 0 in WAIT -> all outputs 0 next cycle, no rsp_valid for that request, req_ready 1 after reset released.
